// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl shared types: FSM states, instruction classes, opcodes and control codes.
// The TRAP state exists only when MC_CTRL_TRAP_EN is defined.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
`ifdef MC_CTRL_TRAP_EN
        ,
        S_TRAP   = 3'd6
`endif
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_IALU, C_LW, C_SW, C_LUI, C_BEQ, C_JAL, C_ILL
    } cls_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] EXOP_I     = 3'b000;
    localparam logic [2:0] EXOP_U     = 3'b001;
    localparam logic [2:0] EXOP_S     = 3'b010;
    localparam logic [2:0] EXOP_B     = 3'b011;
    localparam logic [2:0] EXOP_J     = 3'b100;
    localparam logic [2:0] EXOP_SHAMT = 3'b101;
    localparam logic [2:0] EXOP_ZI    = 3'b110;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;
    localparam logic [2:0] ALU_SRL  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // The ALU has no signed compare or arithmetic shift: slt/sra fold onto sltu/srl.
    function automatic logic [2:0] alu_of_f3(input logic [2:0] f3, input logic alt);
        logic [2:0] op;
        unique case (f3)
            3'b000:         op = alt ? ALU_SUB : ALU_ADD;
            3'b001:         op = ALU_SLL;
            3'b010, 3'b011: op = ALU_SLTU;
            3'b100:         op = ALU_XOR;
            3'b101:         op = ALU_SRL;
            3'b110:         op = ALU_OR;
            default:        op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier for the multi-cycle controller.
// Produces class, immediate format, ALU operation and a legality flag.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output cls_t        cls,
    output logic [2:0]  exop,
    output logic [2:0]  alu_op,
    output logic        legal
);

    logic [6:0] op;
    logic [2:0] f3;
    logic       alt;
    logic       unused_bits;

    assign op  = instr[6:0];
    assign f3  = instr[14:12];
    assign alt = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        cls    = C_ILL;
        exop   = EXOP_I;
        alu_op = ALU_ADD;
        legal  = 1'b1;
        unique case (1'b1)
            (op == OP_R): begin
                cls    = C_R;
                alu_op = alu_of_f3(f3, alt);
            end
            (op == OP_IALU): begin
                cls    = C_IALU;
                alu_op = alu_of_f3(f3, 1'b0);
                unique case (f3)
                    3'b001, 3'b101: exop = EXOP_SHAMT;
                    3'b011:         exop = EXOP_ZI;
                    default:        exop = EXOP_I;
                endcase
            end
            (op == OP_LW): cls = C_LW;
            (op == OP_SW): begin
                cls  = C_SW;
                exop = EXOP_S;
            end
            (op == OP_LUI): begin
                cls  = C_LUI;
                exop = EXOP_U;
            end
            (op == OP_BEQ && f3 == 3'b000): begin
                cls    = C_BEQ;
                exop   = EXOP_B;
                alu_op = ALU_SUB;
            end
            (op == OP_JAL): begin
                cls  = C_JAL;
                exop = EXOP_J;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control FSM over a single shared memory port.
// Define MC_CTRL_TRAP_EN to trap on illegal instructions instead of NOP-ing them.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic [2:0]  exop,
    output logic [2:0]  state
`ifdef MC_CTRL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    state_t     st;
    cls_t       cls;
    logic [2:0] dec_exop;
    logic [2:0] dec_alu;
    logic       legal;

    mc_decode u_dec (
        .instr  (instr),
        .cls    (cls),
        .exop   (dec_exop),
        .alu_op (dec_alu),
        .legal  (legal)
    );

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= S_IDLE;
            exop <= EXOP_I;
        end else begin
            unique case (st)
                S_IDLE:  st <= S_FETCH;
                S_FETCH: if (mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    exop <= dec_exop;
`ifdef MC_CTRL_TRAP_EN
                    st   <= legal ? S_EXEC : S_TRAP;
`else
                    st   <= legal ? S_EXEC : S_FETCH;
`endif
                end
                S_EXEC: begin
                    unique case (cls)
                        C_R, C_IALU, C_LUI: st <= S_WB;
                        C_LW, C_SW:         st <= S_MEM;
                        default:            st <= S_FETCH;
                    endcase
                end
                S_MEM: if (mem_ready) st <= (cls == C_SW) ? S_FETCH : S_WB;
                S_WB:  st <= S_FETCH;
`ifdef MC_CTRL_TRAP_EN
                S_TRAP: st <= S_TRAP;
`endif
                default: st <= S_IDLE;
            endcase
        end
    end

    // Controls are decoded from the live state so reset clears them at once.
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        mem_sel = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 1'b0;
        reg_we  = 1'b0;
        wb_sel  = WB_ALU;
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
`ifdef MC_CTRL_TRAP_EN
        illegal = 1'b0;
`endif
        unique case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_DECODE: begin
`ifndef MC_CTRL_TRAP_EN
                pc_we = !legal;
`endif
            end
            S_EXEC: begin
                alu_op  = dec_alu;
                alu_src = (cls == C_IALU) || (cls == C_LW) || (cls == C_SW);
                if (cls == C_BEQ) begin
                    pc_we  = 1'b1;
                    pc_sel = zero;
                end
                if (cls == C_JAL) begin
                    reg_we = 1'b1;
                    wb_sel = WB_PC4;
                    pc_we  = 1'b1;
                    pc_sel = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (cls == C_SW);
                pc_we   = mem_ready && (cls == C_SW);
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                wb_sel = (cls == C_LW)  ? WB_MEM :
                         (cls == C_LUI) ? WB_IMM : WB_ALU;
            end
`ifdef MC_CTRL_TRAP_EN
            S_TRAP: illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: per-cycle scoreboard of mc_ctrl outputs against an instruction-level model.
// Works with or without MC_CTRL_TRAP_EN.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        mem_req, mem_we, mem_sel, ir_we, pc_we, pc_sel, reg_we, alu_src;
    logic [1:0]  wb_sel;
    logic [2:0]  alu_op, exop, state;
    logic        ill_w;

`ifdef MC_CTRL_TRAP_EN
    localparam bit TRAP = 1'b1;
    logic illegal;
    assign ill_w = illegal;
`else
    localparam bit TRAP = 1'b0;
    assign ill_w = 1'b0;
`endif

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .mem_ready (mem_ready),
        .zero      (zero),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .exop      (exop),
        .state     (state)
`ifdef MC_CTRL_TRAP_EN
        ,
        .illegal   (illegal)
`endif
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [19:0] expq[$];
    logic [19:0] ce, cg;
    logic [2:0]  prev_exop = 3'b000;

    // Instruction kinds: 0 R, 1 I-ALU, 2 lw, 3 sw, 4 lui, 5 beq, 6 jal, 7 illegal.
    function automatic int kind(input logic [31:0] i);
        case (i[6:0])
            7'h33: return 0;
            7'h13: return 1;
            7'h03: return 2;
            7'h23: return 3;
            7'h37: return 4;
            7'h63: return (i[14:12] == 3'b000) ? 5 : 7;
            7'h6F: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic logic [2:0] m_exop(input logic [31:0] i);
        case (kind(i))
            1: return (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'b101 :
                      (i[14:12] == 3'b011) ? 3'b110 : 3'b000;
            3: return 3'b010;
            4: return 3'b001;
            5: return 3'b011;
            6: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] m_alu(input logic [31:0] i);
        logic [2:0] tbl [8];
        int k;
        tbl = '{3'd0, 3'd5, 3'd7, 3'd7, 3'd4, 3'd6, 3'd3, 3'd2};
        k = kind(i);
        if (k == 5) return 3'b001;
        if (k > 1) return 3'b000;
        if (k == 0 && i[14:12] == 3'b000 && i[30]) return 3'b001;
        return tbl[i[14:12]];
    endfunction

    function automatic logic [19:0] mk(
        input logic ill, input logic [2:0] st, input logic req, input logic we,
        input logic msel, input logic irwe, input logic pcwe, input logic pcsel,
        input logic regwe, input logic [1:0] wbs, input logic asrc,
        input logic [2:0] alu, input logic [2:0] exo);
        return {ill, st, req, we, msel, irwe, pcwe, pcsel, regwe, wbs, asrc, alu, exo};
    endfunction

    function automatic logic [19:0] outs();
        return {ill_w, state, mem_req, mem_we, mem_sel, ir_we, pc_we, pc_sel,
                reg_we, wb_sel, alu_src, alu_op, exop};
    endfunction

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            ce = expq.pop_front();
            cg = outs();
            n_chk++;
            if (cg !== ce) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got=%b required=%b", $time, cg, ce);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int req);
        n_chk++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", nm, got, req);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        prev_exop = 3'b000;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            instr = $urandom;
            expq.push_back(20'h0);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input int zm, input bit abort, output int ncyc);
        int k;
        logic [2:0] ne, al;
        logic z, ms, ws;
        k = kind(ins);
        ne = m_exop(ins);
        al = m_alu(ins);
        ncyc = 0;
        for (int i = 0; i <= fw; i++) begin
            @(posedge clk); #1;
            if (i == 0) instr = ins;
            mem_ready = (i == fw);
            zero = 1'($urandom);
            expq.push_back(mk(0, 3'd1, 1, 0, 0, (i == fw), 0, 0, 0, 2'b00, 0, 3'b000, prev_exop));
            ncyc++;
        end
        @(posedge clk); #1;
        mem_ready = 1'($urandom);
        zero = 1'($urandom);
        expq.push_back(mk(0, 3'd2, 0, 0, 0, 0, (k == 7 && !TRAP), 0, 0, 2'b00, 0, 3'b000, prev_exop));
        ncyc++;
        prev_exop = ne;
        if (k == 7) return;
        @(posedge clk); #1;
        mem_ready = 1'($urandom);
        z = (zm < 0) ? 1'($urandom) : zm[0];
        zero = z;
        expq.push_back(mk(0, 3'd3, 0, 0, 0, 0, (k == 5 || k == 6), (k == 5) ? z : (k == 6),
                          (k == 6), (k == 6) ? 2'b10 : 2'b00, (k == 1 || k == 2 || k == 3), al, ne));
        ncyc++;
        if (k == 5 || k == 6) return;
        if (k == 2 || k == 3) begin
            for (int j = 0; j <= mw; j++) begin
                @(posedge clk); #1;
                mem_ready = (j == mw);
                zero = 1'($urandom);
                ms = (k == 3);
                ws = (k == 3 && j == mw);
                expq.push_back(mk(0, 3'd4, 1, ms, 1, 0, ws, 0, 0, 2'b00, 0, 3'b000, ne));
                ncyc++;
                if (abort && j == 1) begin
                    @(negedge clk); #1;
                    mem_ready = 1'b1;
                    rst_n = 1'b0;
                    #1;
                    chk("rst_mid_mem_state", int'(state), 0);
                    chk("rst_mid_mem_req", int'(mem_req), 0);
                    chk("rst_mid_mem_outputs", int'(outs()), 0);
                    prev_exop = 3'b000;
                    ncyc = -1;
                    return;
                end
            end
            if (k == 3) return;
        end
        @(posedge clk); #1;
        mem_ready = 1'($urandom);
        zero = 1'($urandom);
        expq.push_back(mk(0, 3'd5, 0, 0, 0, 0, 1, 0, 1,
                          (k == 2) ? 2'b01 : (k == 4) ? 2'b11 : 2'b00, 0, 3'b000, ne));
        ncyc++;
    endtask

    initial begin
        int nc, k;
        logic [31:0] ins;
        logic [6:0] bad [5];
        bad = '{7'h7F, 7'h17, 7'h67, 7'h73, 7'h0F};

        do_reset(3);

        run_instr(32'h00500093, 0, 0, -1, 0, nc);
        chk("addi_cycles", nc, 4);
        chk("addi_exop", int'(exop), 0);
        run_instr(32'h0000A103, 0, 2, -1, 0, nc);
        chk("lw_wait2_cycles", nc, 7);
        run_instr(32'h0020A223, 1, 1, -1, 0, nc);
        chk("sw_cycles", nc, 6);
        chk("sw_exop", int'(exop), 2);
        run_instr(32'h00000063, 0, 0, 1, 0, nc);
        chk("beq_z1_cycles", nc, 3);
        chk("beq_exop", int'(exop), 3);
        run_instr(32'h00000063, 0, 0, 0, 0, nc);
        chk("beq_z0_cycles", nc, 3);
        run_instr(32'h00109093, 0, 0, -1, 0, nc);
        chk("slli_exop", int'(exop), 5);
        run_instr(32'h0010B093, 0, 0, -1, 0, nc);
        chk("sltiu_exop", int'(exop), 6);
        run_instr(32'h123450B7, 0, 0, -1, 0, nc);
        chk("lui_exop", int'(exop), 1);
        chk("lui_cycles", nc, 4);
        run_instr(32'h008000EF, 0, 0, -1, 0, nc);
        chk("jal_exop", int'(exop), 4);
        chk("jal_cycles", nc, 3);
        run_instr(32'h402081B3, 0, 0, -1, 0, nc);
        chk("sub_cycles", nc, 4);
`ifndef MC_CTRL_TRAP_EN
        run_instr(32'h0000007F, 0, 0, -1, 0, nc);
        chk("nop_cycles", nc, 2);
`endif

        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 8);
            ins = $urandom;
            case (k)
                0: ins[6:0] = 7'h33;
                1, 2: ins[6:0] = 7'h13;
                3: begin ins[6:0] = 7'h03; ins[14:12] = 3'b010; end
                4: begin ins[6:0] = 7'h23; ins[14:12] = 3'b010; end
                5: ins[6:0] = 7'h37;
                6: begin
                    ins[6:0] = 7'h63;
                    if (TRAP || $urandom_range(0, 3) != 0) ins[14:12] = 3'b000;
                end
                7: ins[6:0] = 7'h6F;
                default: ins[6:0] = TRAP ? 7'h13 : bad[$urandom_range(0, 4)];
            endcase
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), -1, 0, nc);
        end

        run_instr(32'h0000A103, 0, 3, -1, 1, nc);
        do_reset(2);
        run_instr(32'h00500093, 0, 0, -1, 0, nc);
        chk("addi_after_reset_cycles", nc, 4);

`ifdef MC_CTRL_TRAP_EN
        run_instr(32'h0000007F, 0, 0, -1, 0, nc);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            expq.push_back(mk(1, 3'd6, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 3'b000, 3'b000));
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("trap_reset_state", int'(state), 0);
        chk("trap_reset_illegal", int'(ill_w), 0);
        do_reset(2);
`endif

        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
